// File: rtl/cl_pkg.sv
// Shared encodings for the multicycle count-leading/trailing custom instruction.
package cl_pkg;

  // Operation select carried on the n port.
  typedef enum logic [1:0] {
    CL_MODE_CLO = 2'd0,
    CL_MODE_CLZ = 2'd1,
    CL_MODE_CTO = 2'd2,
    CL_MODE_CTZ = 2'd3
  } cl_mode_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    CL_IDLE = 2'd0,
    CL_SCAN = 2'd1,
    CL_DONE = 2'd2
  } cl_state_e;

endpackage

// File: rtl/cl_chunk_count.sv
// Combinational leading-ones counter over one CHUNK-bit slice.
module cl_chunk_count
  import cl_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]       bits,
  output logic [$clog2(CHUNK):0] ones
);

  localparam int OW = $clog2(CHUNK) + 1;

  logic stop;

  // Walk from the MSB, counting ones until the first zero.
  always_comb begin
    ones = '0;
    stop = 1'b0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (!stop) begin
        if (bits[CHUNK-1-i]) begin
          ones = ones + OW'(1);
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/count_leading_multi.sv
// Nios II multicycle custom instruction: CLO/CLZ/CTO/CTZ, scanning CHUNK bits
// per enabled cycle and terminating early at the first chunk with a zero.
module count_leading_multi
  import cl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [1:0]       n,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(WIDTH) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int OW     = $clog2(CHUNK) + 1;

  cl_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] norm;
  logic [OW-1:0]    chunk_ones;
  logic [CW-1:0]    scan_sum;
  logic             chunk_full;
  logic             last_chunk;

  // Map every mode onto a leading-ones count of the loaded operand.
  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rev[i] = dataa[WIDTH-1-i];
    end
    case (cl_mode_e'(n))
      CL_MODE_CLO: norm = dataa;
      CL_MODE_CLZ: norm = ~dataa;
      CL_MODE_CTO: norm = rev;
      CL_MODE_CTZ: norm = ~rev;
      default:     norm = dataa;
    endcase
  end

  cl_chunk_count #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .bits (shift_q[WIDTH-1 -: CHUNK]),
    .ones (chunk_ones)
  );

  assign scan_sum   = count_q + CW'(chunk_ones);
  assign chunk_full = (chunk_ones == OW'(CHUNK));
  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  // Next-state and datapath update; nothing moves while clk_en is low.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    idx_d    = idx_q;
    done_d   = done_q;
    result_d = result_q;
    if (clk_en) begin
      case (state_q)
        CL_IDLE: begin
          if (start) begin
            shift_d = norm;
            count_d = '0;
            idx_d   = '0;
            state_d = CL_SCAN;
          end
        end
        CL_SCAN: begin
          count_d = scan_sum;
          if (chunk_full && !last_chunk) begin
            shift_d = shift_q << CHUNK;
            idx_d   = idx_q + IW'(1);
          end else begin
            result_d = WIDTH'(scan_sum);
            done_d   = 1'b1;
            state_d  = CL_DONE;
          end
        end
        CL_DONE: begin
          done_d  = 1'b0;
          state_d = CL_IDLE;
        end
        default: begin
          done_d  = 1'b0;
          state_d = CL_IDLE;
        end
      endcase
    end
  end

  // State register; reset overrides clk_en and abandons any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CL_IDLE;
      shift_q  <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_count_leading_multi.sv
// Self-checking bench for count_leading_multi (WIDTH=32, CHUNK=8).
module tb_count_leading_multi;

  localparam int W  = 32;
  localparam int CH = 8;
  localparam int NCH = W / CH;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          start;
  logic [W-1:0]  dataa;
  logic [1:0]    n;
  logic          done;
  logic [W-1:0]  result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit check_en = 1'b0;

  count_leading_multi #(
    .WIDTH (W),
    .CHUNK (CH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .n      (n),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference count straight from the mode definitions, no normalisation.
  function automatic int ref_count(input logic [W-1:0] d, input logic [1:0] m);
    int  c;
    bit  want;
    c = 0;
    want = (m == 2'd0) || (m == 2'd2);
    if (m < 2'd2) begin
      for (int i = W - 1; i >= 0; i--) begin
        if (d[i] != want) break;
        c++;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (d[i] != want) break;
        c++;
      end
    end
    return c;
  endfunction

  // Enabled edges from acceptance until done rises.
  function automatic int ref_edges(input int cnt);
    int j;
    j = cnt / CH;
    if (j > NCH - 1) j = NCH - 1;
    return j + 1;
  endfunction

  // Behavioural model: an accepted op completes after a known number of enabled edges.
  bit       m_busy, m_done;
  int       m_rem, m_val;
  logic [W-1:0] m_res;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_rem  <= 0;
    end else if (clk_en) begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (m_busy) begin
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_res  <= W'(m_val);
          m_busy <= 1'b0;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_val  <= ref_count(dataa, n);
        m_rem  <= ref_edges(ref_count(dataa, n));
      end
    end
  end

  // Compare outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_result", 64'(result), 64'(m_res));
    end
  end

  task automatic run_op(input logic [W-1:0] d, input logic [1:0] m,
                        input int exp_res, input int exp_lat, input string nm);
    int t0, lat;
    @(posedge clk); #1;
    start = 1'b1; dataa = d; n = m; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; dataa = $urandom; n = 2'($urandom);
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_result"}, 64'(result), 64'(exp_res));
  endtask

  function automatic logic [W-1:0] gen_data();
    int s;
    logic [W-1:0] ones;
    ones = '1;
    s = $urandom_range(0, W);
    case ($urandom % 5)
      0: return $urandom;
      1: return ~(ones >> s);
      2: return ones >> s;
      3: return ones << s;
      default: return ~(ones << s) | (($urandom) & (ones << (s + 1)));
    endcase
  endfunction

  initial begin
    int t0, first, ndone;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = '0; n = 2'd0;
    @(posedge clk); #1;
    check_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);

    run_op(32'hFFFF0000, 2'd0, 16, 4, "clo_ffff0000");
    run_op(32'h00000001, 2'd1, 31, 5, "clz_00000001");
    run_op(32'h7FFFFFFF, 2'd0, 0, 2, "clo_7fffffff");
    run_op(32'hFFFFFFFF, 2'd0, 32, 5, "clo_ffffffff");
    run_op(32'h00000100, 2'd3, 8, 3, "ctz_00000100");
    run_op(32'h00000007, 2'd2, 3, 2, "cto_00000007");
    run_op(32'h00000000, 2'd1, 32, 5, "clz_zero");
    run_op(32'h80000000, 2'd3, 31, 5, "ctz_80000000");

    // clk_en stall in SCAN plus a stray start that must be ignored.
    @(posedge clk); #1;
    start = 1'b1; dataa = 32'hFFFF0000; n = 2'd0; t0 = cyc;
    first = -1; ndone = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first < 0) first = cyc - t0;
      end
      start = 1'b0;
      clk_en = !((cyc - t0) >= 2 && (cyc - t0) <= 4);
      if ((cyc - t0) == 5) begin
        start = 1'b1; dataa = 32'h00000000; n = 2'd1;
      end
    end
    clk_en = 1'b1; start = 1'b0;
    check("stall_latency", 64'(first), 64'd7);
    check("stall_done_count", 64'(ndone), 64'd1);
    check("stall_result", 64'(result), 64'd16);

    // Reset in the middle of a full-length scan.
    @(posedge clk); #1;
    start = 1'b1; dataa = 32'hFFFFFFFF; n = 2'd0; t0 = cyc;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      start = 1'b0;
      reset = ((cyc - t0) == 2);
    end
    reset = 1'b0;
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    run_op(32'hFFFF0000, 2'd0, 16, 4, "after_abort");

    // Randomised traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      clk_en = ($urandom % 8) != 0;
      start  = ($urandom % 3) == 0;
      n      = 2'($urandom);
      dataa  = gen_data();
      reset  = ($urandom % 250) == 0;
    end
    reset = 1'b0; clk_en = 1'b1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_leading_multi.md
COUNT_LEADING_MULTI -- requirements
Module: count_leading_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; power of two, 8 to 64.
REQ-002 SHALL have parameter CHUNK, default 8: bits examined per scan cycle; power of two; WIDTH multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port clk_en  input  1  Nios II custom-instruction clock enable.
REQ-006 SHALL have port start  input  1  operation request, sampled in IDLE.
REQ-007 SHALL have port dataa  input  WIDTH  operand.
REQ-008 SHALL have port n  input  2  mode select: 0 CLO, 1 CLZ, 2 CTO, 3 CTZ.
REQ-009 SHALL have port done  output  1  one-cycle completion strobe.
REQ-010 SHALL have port result  output  WIDTH  count, zero-extended, range 0..WIDTH.

Function
REQ-011 SHALL implement a Nios II multicycle custom instruction: variable latency, early termination.
REQ-012 SHALL use FSM states IDLE, SCAN, DONE.
REQ-013 IDLE: on clk_en=1 and start=1, SHALL load the normalised operand into a shift register, clear the count and the chunk index, and go to SCAN.
REQ-014 Normalisation SHALL be: CLO as-is; CLZ inverted; CTO bit-reversed; CTZ bit-reversed then inverted. Every mode then reduces to counting leading ones.
REQ-015 SCAN: each clk_en cycle SHALL examine the top CHUNK bits. All ones: add CHUNK to count, shift left by CHUNK, advance the index. Otherwise: add the chunk's leading-one count and go to DONE.
REQ-016 SCAN SHALL go to DONE when the last chunk (index WIDTH/CHUNK-1) is examined, whatever its value.
REQ-017 On the SCAN-to-DONE transition, result SHALL be registered with the final count.
REQ-018 DONE: done SHALL be 1 for exactly one clk_en cycle; the FSM SHALL then return to IDLE.
REQ-019 Latency SHALL be: start accepted in cycle T, terminating chunk j (0-based) gives done=1 in cycle T+2+j. Minimum 2 cycles; maximum WIDTH/CHUNK+1 cycles.
REQ-020 result SHALL hold its value after done until the next completion.
REQ-021 start SHALL be ignored in SCAN and DONE; it SHALL NOT abort or restart an operation.
REQ-022 clk_en=0 SHALL freeze all state, count, index and outputs; done SHALL hold its current value.
REQ-023 dataa and n SHALL be sampled only at start acceptance; later changes SHALL have no effect.
REQ-024 Count register SHALL be $clog2(WIDTH)+1 bits, so the all-ones count WIDTH does not wrap.

Reset
REQ-025 reset SHALL take priority over clk_en and start.
REQ-026 On reset: state IDLE, done=0, result=0, count=0, shift register=0.
REQ-027 Reset during SCAN or DONE SHALL abandon the operation; done SHALL NOT assert for it.

Structure
REQ-028 Package cl_pkg SHALL hold the mode encodings (CL_MODE_CLO/CLZ/CTO/CTZ) and the FSM state type.
REQ-029 Sub-module cl_chunk_count SHALL be a combinational leading-ones counter over CHUNK bits, output $clog2(CHUNK)+1 bits; instantiated once.
REQ-030 The bit-reversal and inversion network SHALL be purely combinational, ahead of the load register.

Verification (WIDTH=32, CHUNK=8; T = start-accept cycle)
REQ-031 n=0, dataa=0xFFFF0000 -> result=16, done in T+4.
REQ-032 n=1, dataa=0x00000001 -> result=31, done in T+5; n=0, dataa=0x7FFFFFFF -> result=0, done in T+2.
REQ-033 n=0, dataa=0xFFFFFFFF -> result=32 (no wrap), done in T+5.
REQ-034 n=3, dataa=0x00000100 -> result=8, done in T+3; n=2, dataa=0x00000007 -> result=3, done in T+2.
REQ-035 n=0, dataa=0xFFFF0000, clk_en low 3 cycles during SCAN -> done in T+7, result=16; start pulsed in SCAN -> ignored, exactly one done.
REQ-036 reset asserted in T+2 of a 32-bit CLO -> no done, result=0, state IDLE; next start then completes normally.
